// File: rtl/dsp_post_accum.sv
// Post-multiplier add/subtract/accumulate stage. It has optional input registers,
// a 48-bit accumulator, and cascade and carry outputs.
module dsp_post_accum #(
  parameter int    MREG       = 1,
  parameter int    CREG       = 1,
  parameter int    OPMODEREG  = 1,
  parameter int    CARRYINREG = 1,
  parameter int    PREG       = 1,
  parameter string CARRYINSEL = "OPMODE5"
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [35:0] M,
  input  logic [47:0] DAB,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic [7:0]  OPMODE,
  input  logic        CARRYIN,
  input  logic        CEM,
  input  logic        CEC,
  input  logic        CEOPMODE,
  input  logic        CECARRYIN,
  input  logic        CEP,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  localparam bit USE_OPMODE5 = (CARRYINSEL == "OPMODE5");

  logic [35:0] m_d, m_q, m_s;
  logic [47:0] c_d, c_q, c_s;
  logic [7:0]  opmode_d, opmode_q, opmode_s;
  logic        cin_d, cin_q, cin_s, cin_src;
  logic [47:0] acc_d, acc_q;
  logic        co_d, co_q;
  logic [47:0] x_mux, z_mux;
  logic [48:0] x_ext, z_ext, sum;
  logic        unused_opmode_bits;

  assign unused_opmode_bits = ^{opmode_s[6], opmode_s[4]};

  always_comb begin
    m_d      = CEM       ? M      : m_q;
    c_d      = CEC       ? C      : c_q;
    opmode_d = CEOPMODE  ? OPMODE : opmode_q;

    m_s      = (MREG      != 0) ? m_q      : M;
    c_s      = (CREG      != 0) ? c_q      : C;
    opmode_s = (OPMODEREG != 0) ? opmode_q : OPMODE;

    // Carry source comes after the OPMODE stage, so with both registered it trails by one edge.
    cin_src  = USE_OPMODE5 ? opmode_s[5] : CARRYIN;
    cin_d    = CECARRYIN ? cin_src : cin_q;
    cin_s    = (CARRYINREG != 0) ? cin_q : cin_src;
  end

  // Feedback always comes from acc_q, which keeps PREG=0 free of combinational loops.
  always_comb begin
    x_mux = '0;
    unique case (opmode_s[1:0])
      2'b00: x_mux = '0;
      2'b01: x_mux = {12'b0, m_s};
      2'b10: x_mux = acc_q;
      2'b11: x_mux = DAB;
    endcase
    z_mux = '0;
    unique case (opmode_s[3:2])
      2'b00: z_mux = '0;
      2'b01: z_mux = PCIN;
      2'b10: z_mux = acc_q;
      2'b11: z_mux = c_s;
    endcase
    x_ext = {1'b0, x_mux} + {48'b0, cin_s};
    z_ext = {1'b0, z_mux};
    sum   = opmode_s[7] ? (z_ext - x_ext) : (z_ext + x_ext);
    acc_d = CEP ? sum[47:0] : acc_q;
    co_d  = CEP ? sum[48]   : co_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_q      <= '0;
      c_q      <= '0;
      opmode_q <= '0;
      cin_q    <= 1'b0;
      acc_q    <= '0;
      co_q     <= 1'b0;
    end else begin
      m_q      <= m_d;
      c_q      <= c_d;
      opmode_q <= opmode_d;
      cin_q    <= cin_d;
      acc_q    <= acc_d;
      co_q     <= co_d;
    end
  end

  always_comb begin
    P         = (PREG != 0) ? acc_q : sum[47:0];
    CARRYOUT  = (PREG != 0) ? co_q  : sum[48];
    PCOUT     = P;
    CARRYOUTF = CARRYOUT;
  end

endmodule

// File: tb/tb_dsp_post_accum.sv
// Bench for dsp_post_accum. It drives a fully registered instance and a fully bypassed one
// with the same inputs and checks both against a plain-arithmetic model.
module tb_dsp_post_accum;

  logic        CLK, RST_N;
  logic [35:0] M;
  logic [47:0] DAB, C, PCIN;
  logic [7:0]  OPMODE;
  logic        CARRYIN, CEM, CEC, CEOPMODE, CECARRYIN, CEP;

  logic [47:0] p_a, pcout_a, p_b, pcout_b;
  logic        co_a, cof_a, co_b, cof_b;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [47:0] ONES48 = 48'hFFFF_FFFF_FFFF;

  dsp_post_accum dut (
    .CLK(CLK), .RST_N(RST_N), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
    .OPMODE(OPMODE), .CARRYIN(CARRYIN), .CEM(CEM), .CEC(CEC),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .CEP(CEP),
    .P(p_a), .PCOUT(pcout_a), .CARRYOUT(co_a), .CARRYOUTF(cof_a)
  );

  dsp_post_accum #(
    .MREG(0), .CREG(0), .OPMODEREG(0), .CARRYINREG(0), .PREG(0),
    .CARRYINSEL("CARRYIN")
  ) dut_bp (
    .CLK(CLK), .RST_N(RST_N), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN),
    .OPMODE(OPMODE), .CARRYIN(CARRYIN), .CEM(CEM), .CEC(CEC),
    .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN), .CEP(CEP),
    .P(p_b), .PCOUT(pcout_b), .CARRYOUT(co_b), .CARRYOUTF(cof_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Result of one operation as a 49-bit value: {carry, sum}.
  function automatic logic [48:0] alu(input logic [7:0] op, input logic [35:0] m,
                                      input logic [47:0] c, input logic [47:0] dab,
                                      input logic [47:0] pcin, input logic [47:0] acc,
                                      input logic cin);
    longint unsigned x, z, r;
    case (op[1:0])
      2'd0: x = 64'd0;
      2'd1: x = {28'b0, m};
      2'd2: x = {16'b0, acc};
      default: x = {16'b0, dab};
    endcase
    case (op[3:2])
      2'd0: z = 64'd0;
      2'd1: z = {16'b0, pcin};
      2'd2: z = {16'b0, acc};
      default: z = {16'b0, c};
    endcase
    r = op[7] ? (z - x - 64'(cin)) : (z + x + 64'(cin));
    return r[48:0];
  endfunction

  logic [35:0] a_m;
  logic [47:0] a_c, a_acc, b_acc;
  logic [7:0]  a_op;
  logic        a_cin, a_co, b_co;
  logic [48:0] b_now;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_m <= '0; a_c <= '0; a_op <= '0; a_cin <= 1'b0; a_acc <= '0; a_co <= 1'b0;
      b_acc <= '0; b_co <= 1'b0;
    end else begin
      if (CEP) begin
        {a_co, a_acc} <= alu(a_op, a_m, a_c, DAB, PCIN, a_acc, a_cin);
        {b_co, b_acc} <= alu(OPMODE, M, C, DAB, PCIN, b_acc, CARRYIN);
      end
      if (CEM)       a_m   <= M;
      if (CEC)       a_c   <= C;
      if (CEOPMODE)  a_op  <= OPMODE;
      if (CECARRYIN) a_cin <= a_op[5];
    end
  end

  task automatic check(input string name, input logic [48:0] act, input logic [48:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    b_now = alu(OPMODE, M, C, DAB, PCIN, b_acc, CARRYIN);
    check("P_a",        {1'b0, p_a},     {1'b0, a_acc});
    check("PCOUT_a",    {1'b0, pcout_a}, {1'b0, a_acc});
    check("CARRYOUT_a", {48'b0, co_a},   {48'b0, a_co});
    check("CARRYOUTF_a",{48'b0, cof_a},  {48'b0, a_co});
    check("P_b",        {co_b, p_b},     b_now);
    check("PCOUT_b",    {cof_b, pcout_b}, b_now);
  end

  task automatic slot();
    @(negedge CLK);
    #2;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    M = '0; DAB = '0; C = '0; PCIN = '0; OPMODE = '0; CARRYIN = 1'b0;
    CEM = 1'b1; CEC = 1'b1; CEOPMODE = 1'b1; CECARRYIN = 1'b1; CEP = 1'b1;

    slot();
    check("rst_P",     {1'b0, p_a},     49'd0);
    check("rst_PCOUT", {1'b0, pcout_a}, 49'd0);
    check("rst_CO",    {48'b0, co_a},   49'd0);
    check("rst_COF",   {48'b0, cof_a},  49'd0);
    RST_N = 1'b1;
    OPMODE = 8'h0D; C = 48'd100; M = 36'd23;
    edges(2);
    check("add_P",  {co_a, p_a}, 49'd123);

    slot();
    RST_N = 1'b0; #1; RST_N = 1'b1;
    OPMODE = 8'h09; M = 36'd5;
    edges(2); check("acc_5",  {co_a, p_a}, 49'd5);
    edges(1); check("acc_10", {co_a, p_a}, 49'd10);
    edges(1); check("acc_15", {co_a, p_a}, 49'd15);
    edges(1); check("acc_20", {co_a, p_a}, 49'd20);
    slot(); CEP = 1'b0;
    edges(1); check("acc_hold", {co_a, p_a}, 49'd20);
    slot(); CEP = 1'b1;
    edges(1); check("acc_25", {co_a, p_a}, 49'd25);

    slot();
    RST_N = 1'b0; #1;
    check("arst_P",  {1'b0, p_a},   49'd0);
    check("arst_CO", {48'b0, co_a}, 49'd0);
    RST_N = 1'b1;
    edges(2); check("arst_restart5",  {co_a, p_a}, 49'd5);
    edges(1); check("arst_restart10", {co_a, p_a}, 49'd10);

    slot();
    OPMODE = 8'h2C; C = ONES48;
    edges(2); check("wrap_pre",  {co_a, p_a}, {1'b0, ONES48});
    edges(1); check("wrap_P",    {co_a, p_a}, 49'd0 | (49'd1 << 48));
    check("wrap_COF",   {48'b0, cof_a},  49'd1);
    check("wrap_PCOUT", {1'b0, pcout_a}, 49'd0);

    slot();
    OPMODE = 8'h8F; C = 48'd10; DAB = 48'd3;
    edges(3); check("sub_7", {co_a, p_a}, 49'd7);
    slot(); DAB = 48'd11;
    edges(1); check("sub_borrow", {co_a, p_a}, {1'b1, ONES48});

    slot();
    OPMODE = 8'h07; PCIN = 48'd2; DAB = 48'd3; CARRYIN = 1'b0;
    #1; check("byp_P",     {co_b, p_b},     49'd5);
    check("byp_PCOUT",     {cof_b, pcout_b}, 49'd5);
    CARRYIN = 1'b1;
    #1; check("byp_cin",   {co_b, p_b},     49'd6);

    for (int i = 0; i < 400; i++) begin
      slot();
      if ($urandom_range(63) == 0) begin
        RST_N = 1'b0; #1; RST_N = 1'b1;
      end
      M         = {$urandom, $urandom};
      DAB       = ($urandom_range(7) == 0) ? ONES48 : 48'({$urandom, $urandom});
      C         = ($urandom_range(7) == 0) ? ONES48 : 48'({$urandom, $urandom});
      PCIN      = ($urandom_range(7) == 0) ? ONES48 : 48'({$urandom, $urandom});
      OPMODE    = 8'($urandom);
      CARRYIN   = 1'($urandom);
      CEM       = ($urandom_range(3) != 0);
      CEC       = ($urandom_range(3) != 0);
      CEOPMODE  = ($urandom_range(3) != 0);
      CECARRYIN = ($urandom_range(3) != 0);
      CEP       = ($urandom_range(3) != 0);
    end

    slot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
